// File: rtl/arith_op_seq.sv
// Command sequencer for the 4-bit arithmetic unit: programs arith_sel over APB (skipped when
// the op is already loaded), runs one start/finish cycle and returns the result.
module arith_op_seq #(
  parameter logic [31:0] SEL_ADDR       = 32'h0000_0004,
  parameter int unsigned PREADY_TIMEOUT = 16,
  parameter int unsigned FIN_TIMEOUT    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_in1,
  input  logic [3:0]  cmd_in2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_out,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic        pready,
  output logic        alu_start,
  output logic [3:0]  alu_in1,
  output logic [3:0]  alu_in2,
  input  logic [7:0]  alu_out,
  input  logic        alu_err,
  input  logic        alu_finish
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] ACCESS   = 3'd2;
  localparam logic [2:0] START    = 3'd3;
  localparam logic [2:0] WAIT_FIN = 3'd4;
  localparam logic [2:0] RESP     = 3'd5;

  localparam logic [15:0] PREADY_LAST = 16'(PREADY_TIMEOUT - 1);
  localparam logic [15:0] FIN_LAST    = 16'(FIN_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  in1_q, in1_d, in2_q, in2_d;
  logic [1:0]  cache_op_q, cache_op_d;
  logic        cache_valid_q, cache_valid_d;
  logic [7:0]  rsp_out_q, rsp_out_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        apb_sel;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    in1_d         = in1_q;
    in2_d         = in2_q;
    cache_op_d    = cache_op_q;
    cache_valid_d = cache_valid_q;
    rsp_out_d     = rsp_out_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          in1_d   = cmd_in1;
          in2_d   = cmd_in2;
          state_d = (cache_valid_q && (cmd_op == cache_op_q)) ? START : SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          cache_op_d    = op_q;
          cache_valid_d = 1'b1;
          state_d       = START;
        end else if (timer_q == PREADY_LAST) begin
          // The write never landed, so the unit's arith_sel is unknown.
          cache_valid_d = 1'b0;
          rsp_out_d     = 8'hFF;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      START: state_d = WAIT_FIN;
      WAIT_FIN: begin
        if (alu_finish) begin
          rsp_out_d     = alu_out;
          rsp_err_d     = alu_err;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (timer_q == FIN_LAST) begin
          rsp_out_d     = 8'hFF;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Per-state cycle counter, restarted on every state entry.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q == 16'hFFFF) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      op_q          <= '0;
      in1_q         <= '0;
      in2_q         <= '0;
      cache_op_q    <= '0;
      cache_valid_q <= 1'b0;
      rsp_out_q     <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      op_q          <= op_d;
      in1_q         <= in1_d;
      in2_q         <= in2_d;
      cache_op_q    <= cache_op_d;
      cache_valid_q <= cache_valid_d;
      rsp_out_q     <= rsp_out_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign apb_sel     = (state_q == SETUP) || (state_q == ACCESS);
  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_out     = rsp_out_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign psel        = apb_sel;
  assign penable     = (state_q == ACCESS);
  assign pwrite      = apb_sel;
  assign paddr       = apb_sel ? SEL_ADDR : 32'h0;
  assign pwdata      = apb_sel ? {30'b0, op_q} : 32'h0;
  assign alu_start   = (state_q == START) || (state_q == WAIT_FIN);
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;

endmodule

// File: tb/tb_arith_op_seq.sv
// Randomised bench for arith_op_seq: each command is turned into a timeline of expected bus,
// start and response windows, and every cycle's outputs are compared against that timeline.
module tb_arith_op_seq;

  localparam logic [31:0] SEL_ADDR = 32'h0000_0004;
  localparam int PT = 16;
  localparam int FT = 8;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_in1, cmd_in2;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_out;
  logic        rsp_err, rsp_timeout;
  logic        psel, penable, pwrite, pready;
  logic [31:0] paddr, pwdata;
  logic        alu_start, alu_err, alu_finish;
  logic [3:0]  alu_in1, alu_in2;
  logic [7:0]  alu_out;

  arith_op_seq #(
    .SEL_ADDR      (SEL_ADDR),
    .PREADY_TIMEOUT(PT),
    .FIN_TIMEOUT   (FT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_in1    (cmd_in1),
    .cmd_in2    (cmd_in2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pready     (pready),
    .alu_start  (alu_start),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_out    (alu_out),
    .alu_err    (alu_err),
    .alu_finish (alu_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Arithmetic unit: arith_sel loaded by APB writes, finish d_cfg cycles after start rises.
  int         d_cfg = 1;
  int         u_cnt;
  logic [1:0] u_sel = 2'd0;

  function automatic logic [8:0] unit_fn(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    case (op)
      2'd0: return {1'b0, 8'(a) + 8'(b)};
      2'd1: return (a < b) ? {1'b1, 8'hFF} : {1'b0, 8'(a - b)};
      2'd2: return {1'b0, 8'(a) * 8'(b)};
      default: return (b == 4'd0) ? {1'b1, 8'hFF} : {1'b0, 8'(a / b)};
    endcase
  endfunction

  always @(posedge clk) begin
    if (psel && penable && pwrite && pready && paddr == SEL_ADDR) u_sel <= pwdata[1:0];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_cnt      <= 0;
      alu_finish <= 1'b0;
      alu_out    <= 8'h00;
      alu_err    <= 1'b0;
    end else begin
      u_cnt      <= alu_start ? u_cnt + 1 : 0;
      alu_finish <= alu_start && (u_cnt + 1 == d_cfg);
      {alu_err, alu_out} <= unit_fn(u_sel, alu_in1, alu_in2);
    end
  end

  // Reference model: cache tracking plus absolute cycle windows of the current command.
  logic       m_cv = 1'b0;
  logic [1:0] m_cop = 2'd0;
  int t_hs = -100, setup_c = -100, acc_lo = -100, acc_hi = -200;
  int st_lo = -100, st_hi = -200, rs_lo = -100, rs_hi = -200;
  int w_cfg, r_cfg;
  logic [1:0] e_op = 2'd0;
  logic [3:0] e_in1 = 4'd0, e_in2 = 4'd0, p_in1 = 4'd0, p_in2 = 4'd0;
  logic [7:0] e_out;
  logic       e_err, e_to;
  logic       chk_en = 1'b0;

  int cap_lat, cap_psel, cap_acc;
  logic [7:0]  cap_out;
  logic        cap_err, cap_to;
  logic [31:0] cap_wdata;

  function automatic logic [8:0] model(input logic [1:0] op, input int a, input int b);
    int r;
    case (op)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: r = a * b;
      default: r = (b == 0) ? -1 : a / b;
    endcase
    if (r < 0) return {1'b1, 8'hFF};
    return {1'b0, 8'(r)};
  endfunction

  task automatic plan(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input int w, input int d, input int r);
    int s;
    logic [8:0] res;
    t_hs = cyc; w_cfg = w; d_cfg = d; r_cfg = r;
    p_in1 = e_in1; p_in2 = e_in2; e_in1 = a; e_in2 = b; e_op = op;
    setup_c = -100; acc_lo = -100; acc_hi = -200; st_lo = -100; st_hi = -200;
    cap_lat = -1; cap_psel = 0; cap_acc = 0; cap_wdata = 32'hDEAD;
    s = cyc + 1;
    if (!(m_cv && m_cop == op)) begin
      setup_c = cyc + 1;
      acc_lo  = cyc + 2;
      if (w < PT) begin
        acc_hi = acc_lo + w;
        m_cv = 1'b1; m_cop = op;
        s = acc_hi + 1;
      end else begin
        acc_hi = acc_lo + PT - 1;
        m_cv = 1'b0;
        rs_lo = acc_hi + 1;
        e_out = 8'hFF; e_err = 1'b1; e_to = 1'b1;
        s = -1;
      end
    end
    if (s >= 0) begin
      st_lo = s;
      if (d <= FT) begin
        st_hi = s + d;
        res = model(op, a, b);
        e_out = res[7:0]; e_err = res[8]; e_to = 1'b0;
      end else begin
        st_hi = s + FT;
        e_out = 8'hFF; e_err = 1'b1; e_to = 1'b1;
      end
      rs_lo = st_hi + 1;
    end
    rs_hi = rs_lo + r;
  endtask

  always @(negedge clk) begin
    logic e_psel, e_acc, e_rs;
    if (chk_en) begin
      e_acc  = (cyc >= acc_lo && cyc <= acc_hi);
      e_psel = (cyc == setup_c) || e_acc;
      e_rs   = (cyc >= rs_lo && cyc <= rs_hi);
      chk("psel", psel, e_psel);
      chk("penable", penable, e_acc);
      chk("pwrite", pwrite, e_psel);
      if (e_psel) begin
        chk("paddr", paddr, SEL_ADDR);
        chk("pwdata", pwdata, {30'b0, e_op});
      end
      chk("alu_start", alu_start, (cyc >= st_lo && cyc <= st_hi));
      chk("cmd_ready", cmd_ready, !(cyc > t_hs && cyc <= rs_hi));
      chk("rsp_valid", rsp_valid, e_rs);
      if (e_rs) begin
        chk("rsp_out", rsp_out, e_out);
        chk("rsp_err", rsp_err, e_err);
        chk("rsp_timeout", rsp_timeout, e_to);
      end
      chk("alu_in1", alu_in1, (cyc > t_hs) ? e_in1 : p_in1);
      chk("alu_in2", alu_in2, (cyc > t_hs) ? e_in2 : p_in2);
      if (rsp_valid && cap_lat < 0) begin
        cap_lat = cyc - t_hs;
        cap_out = rsp_out; cap_err = rsp_err; cap_to = rsp_timeout;
      end
      if (psel) cap_psel++;
      if (psel && penable) cap_acc++;
      if (psel && penable && pready) cap_wdata = pwdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // While a command is in flight: junk on the command port, scripted pready and rsp_ready.
  task automatic drive_busy();
    cmd_valid = 1'($urandom); cmd_op = 2'($urandom);
    cmd_in1 = 4'($urandom); cmd_in2 = 4'($urandom);
    if (cyc >= acc_lo && cyc <= acc_hi) pready = (cyc == acc_lo + w_cfg);
    else pready = 1'($urandom);
    if (cyc >= rs_lo && cyc <= rs_hi) rsp_ready = (cyc >= rs_lo + r_cfg);
    else rsp_ready = 1'($urandom);
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input int w, input int d, input int r);
    cmd_valid = 1'b1; cmd_op = op; cmd_in1 = a; cmd_in2 = b;
    pready = 1'($urandom); rsp_ready = 1'($urandom);
    plan(op, a, b, w, d, r);
    step();
  endtask

  task automatic run_txn(input int gap, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input int w, input int d, input int r);
    for (int i = 0; i < gap; i++) begin
      cmd_valid = 1'b0; cmd_op = 2'($urandom);
      cmd_in1 = 4'($urandom); cmd_in2 = 4'($urandom);
      pready = 1'($urandom); rsp_ready = 1'($urandom);
      step();
    end
    issue(op, a, b, w, d, r);
    while (cyc <= rs_hi) begin
      drive_busy();
      step();
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    int k, w, d;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_in1 = 4'd0; cmd_in2 = 4'd0;
    rsp_ready = 1'b0; pready = 1'b0;
    repeat (3) step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_out", rsp_out, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_alu_in", {alu_in1, alu_in2}, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    run_txn(0, 2'd0, 4'd3, 4'd4, 0, 1, 0);
    chk("add_lat", cap_lat, 5);
    chk("add_out", cap_out, 8'h07);
    chk("add_err", cap_err, 0);
    chk("add_psel_cycles", cap_psel, 2);
    chk("add_wdata", cap_wdata, 0);

    run_txn(0, 2'd0, 4'd15, 4'd15, 0, 1, 0);
    chk("cached_lat", cap_lat, 3);
    chk("cached_out", cap_out, 8'h1E);
    chk("cached_psel_cycles", cap_psel, 0);

    run_txn(1, 2'd1, 4'd2, 4'd5, 0, 1, 0);
    chk("sub_wdata", cap_wdata, 1);
    chk("sub_out", cap_out, 8'hFF);
    chk("sub_err", cap_err, 1);
    chk("sub_timeout", cap_to, 0);

    run_txn(0, 2'd3, 4'd9, 4'd0, 0, 1, 0);
    chk("div0_out", cap_out, 8'hFF);
    chk("div0_err", cap_err, 1);

    run_txn(0, 2'd0, 4'd5, 4'd5, 30, 1, 0);
    chk("pto_access_cycles", cap_acc, 16);
    chk("pto_lat", cap_lat, 18);
    chk("pto_rsp", {cap_out, cap_err, cap_to}, {8'hFF, 1'b1, 1'b1});

    run_txn(0, 2'd0, 4'd1, 4'd1, 0, 1, 0);
    chk("rewrite_psel_cycles", cap_psel, 2);
    chk("rewrite_out", cap_out, 8'h02);

    run_txn(0, 2'd2, 4'd7, 4'd9, 0, 1, 5);
    chk("mul_out", cap_out, 8'h3F);
    chk("mul_lat", cap_lat, 5);

    run_txn(0, 2'd1, 4'd3, 4'd3, 15, 8, 0);
    chk("late_pready_access", cap_acc, 16);
    chk("late_rsp", {cap_out, cap_err, cap_to}, {8'h00, 1'b0, 1'b0});
    chk("late_lat", cap_lat, 27);

    run_txn(0, 2'd1, 4'd3, 4'd1, 0, 9, 0);
    chk("fto_lat", cap_lat, 10);
    chk("fto_rsp", {cap_out, cap_err, cap_to}, {8'hFF, 1'b1, 1'b1});

    // Asynchronous reset in the middle of an APB access.
    issue(2'd3, 4'd8, 4'd2, 30, 1, 0);
    while (cyc < acc_lo + 2) begin
      drive_busy();
      step();
    end
    drive_busy();
    chk("mid_pre_psel", psel, 1);
    chk("mid_pre_penable", penable, 1);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_alu_start", alu_start, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_cv = 1'b0;
    t_hs = -100; setup_c = -100; acc_lo = -100; acc_hi = -200;
    st_lo = -100; st_hi = -200; rs_lo = -100; rs_hi = -200;
    e_in1 = 4'd0; e_in2 = 4'd0; p_in1 = 4'd0; p_in2 = 4'd0;
    chk_en = 1'b1;
    step();
    run_txn(0, 2'd0, 4'd6, 4'd2, 0, 1, 0);
    chk("post_rst_psel_cycles", cap_psel, 2);
    chk("post_rst_out", cap_out, 8'h08);

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      if (k < 6) w = $urandom_range(0, 3);
      else if (k < 8) w = $urandom_range(0, 15);
      else if (k == 8) w = 15;
      else w = $urandom_range(16, 18);
      k = $urandom_range(0, 9);
      if (k < 7) d = $urandom_range(1, 3);
      else if (k == 7) d = 8;
      else if (k == 8) d = 9;
      else d = $urandom_range(1, 10);
      run_txn($urandom_range(0, 2), 2'($urandom), 4'($urandom), 4'($urandom), w, d,
              $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
